// File: rtl/i2c_sht40_target_pkg.sv
// Shared constants, state encoding and CRC helper for the SHT40 I2C target emulation.
package i2c_sht40_target_pkg;

  localparam logic [6:0] SHT40_ADDR    = 7'h44;
  localparam logic [7:0] CMD_MEAS_HIGH = 8'hFD;
  localparam logic [7:0] CRC8_POLY     = 8'h31;
  localparam logic [7:0] CRC8_INIT     = 8'hFF;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ADDR      = 3'd1,
    ST_ADDR_ACK  = 3'd2,
    ST_CMD       = 3'd3,
    ST_CMD_ACK   = 3'd4,
    ST_TX_BYTE   = 3'd5,
    ST_TX_ACK    = 3'd6,
    ST_WAIT_STOP = 3'd7
  } state_t;

  // Sensirion CRC-8 over one 16-bit word, MSB first, no reflection
  function automatic logic [7:0] crc8_16(input logic [15:0] data);
    logic [7:0] crc;
    crc = CRC8_INIT;
    for (int i = 15; i >= 0; i--) begin
      if (crc[7] ^ data[i]) crc = {crc[6:0], 1'b0} ^ CRC8_POLY;
      else                  crc = {crc[6:0], 1'b0};
    end
    return crc;
  endfunction

endpackage

// File: rtl/i2c_crc8.sv
// Combinational CRC-8 of a 16-bit measurement word.
module i2c_crc8 (
  input  logic [15:0] data,
  output logic [7:0]  crc
);
  import i2c_sht40_target_pkg::*;

  assign crc = crc8_16(data);

endmodule

// File: rtl/i2c_sht40_target.sv
// SHT40-compatible I2C target: address/command decode, measurement countdown,
// and a 6-byte read-back (T_MSB, T_LSB, T_CRC, RH_MSB, RH_LSB, RH_CRC).
module i2c_sht40_target import i2c_sht40_target_pkg::*; #(
  parameter logic [6:0] TARGET_ADDR = SHT40_ADDR,
  parameter int         MEAS_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Scl_In,
  input  logic        Sda_In,
  output logic        Sda_Out,
  input  logic [15:0] Temp_Value,
  input  logic [15:0] RH_Value,
  output logic        Meas_Busy,
  output logic        Data_Ready,
  output logic        Cmd_Error
);

  localparam int CNT_W = (MEAS_CYCLES < 2) ? 1 : $clog2(MEAS_CYCLES + 1);

  logic [1:0]       scl_sync, sda_sync;
  logic             scl_hist, sda_hist;
  logic             scl, sda, scl_rise, scl_fall, start_det, stop_det;
  state_t           state, state_nx;
  logic [3:0]       bit_cnt, bit_cnt_nx;
  logic [7:0]       shreg, shreg_nx;
  logic [2:0]       byte_idx, idx_nx;
  logic             rw_flag, rw_nx;
  logic             sda_r, sda_nx;
  logic             sent, sent_nx;
  logic             meas_start, rd_done, cmd_err_nx, ready_clr;
  logic [CNT_W-1:0] meas_cnt;
  logic [15:0]      t_word, rh_word;
  logic [7:0]       t_crc, rh_crc, t_crc_c, rh_crc_c, tx_data;

  i2c_crc8 u_crc_t  (.data(Temp_Value), .crc(t_crc_c));
  i2c_crc8 u_crc_rh (.data(RH_Value),   .crc(rh_crc_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= 1'b1;
      sda_hist <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], Scl_In};
      sda_sync <= {sda_sync[0], Sda_In};
      scl_hist <= scl_sync[1];
      sda_hist <= sda_sync[1];
    end
  end

  assign scl       = scl_sync[1];
  assign sda       = sda_sync[1];
  assign scl_rise  = scl & ~scl_hist;
  assign scl_fall  = ~scl & scl_hist;
  assign start_det = scl & sda_hist & ~sda;
  assign stop_det  = scl & ~sda_hist & sda;

  always_comb begin
    case (byte_idx)
      3'd0:    tx_data = t_word[15:8];
      3'd1:    tx_data = t_word[7:0];
      3'd2:    tx_data = t_crc;
      3'd3:    tx_data = rh_word[15:8];
      3'd4:    tx_data = rh_word[7:0];
      default: tx_data = rh_crc;
    endcase
  end

  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    idx_nx     = byte_idx;
    rw_nx      = rw_flag;
    sda_nx     = sda_r;
    sent_nx    = sent;
    meas_start = 1'b0;
    rd_done    = 1'b0;
    cmd_err_nx = 1'b0;
    // Bus conditions take priority over whatever the FSM is doing
    if (start_det) begin
      state_nx   = ST_ADDR;
      bit_cnt_nx = 4'd0;
      idx_nx     = 3'd0;
      sda_nx     = 1'b1;
      sent_nx    = 1'b0;
    end else if (stop_det) begin
      state_nx   = ST_IDLE;
      bit_cnt_nx = 4'd0;
      sda_nx     = 1'b1;
      sent_nx    = 1'b0;
    end else begin
      case (state)
        ST_ADDR, ST_CMD: begin
          if (scl_rise && bit_cnt < 4'd8) begin
            shreg_nx   = {shreg[6:0], sda};
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nx = 4'd0;
            state_nx   = ST_WAIT_STOP;
            if (state == ST_ADDR) begin
              rw_nx = shreg[0];
              if (shreg[7:1] == TARGET_ADDR && (!shreg[0] || Data_Ready)) begin
                state_nx = ST_ADDR_ACK;
                sda_nx   = 1'b0;
              end else begin
                state_nx = ST_WAIT_STOP;
              end
            end else if (shreg == CMD_MEAS_HIGH && !Meas_Busy) begin
              state_nx = ST_CMD_ACK;
              sda_nx   = 1'b0;
            end else begin
              cmd_err_nx = (shreg != CMD_MEAS_HIGH);
            end
          end else begin
            state_nx = state;
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall && rw_flag) begin
            state_nx   = ST_TX_BYTE;
            sda_nx     = tx_data[7];
            bit_cnt_nx = 4'd1;
          end else if (scl_fall) begin
            state_nx   = ST_CMD;
            sda_nx     = 1'b1;
            bit_cnt_nx = 4'd0;
          end else begin
            state_nx = state;
          end
        end
        ST_CMD_ACK: begin
          if (scl_fall) begin
            state_nx   = ST_WAIT_STOP;
            sda_nx     = 1'b1;
            meas_start = 1'b1;
          end else begin
            state_nx = state;
          end
        end
        ST_TX_BYTE: begin
          if (scl_fall && bit_cnt == 4'd8) begin
            state_nx   = ST_TX_ACK;
            sda_nx     = 1'b1;
            bit_cnt_nx = 4'd0;
            sent_nx    = 1'b1;
          end else if (scl_fall) begin
            sda_nx     = tx_data[3'd7 - bit_cnt[2:0]];
            bit_cnt_nx = bit_cnt + 4'd1;
          end else begin
            state_nx = state;
          end
        end
        ST_TX_ACK: begin
          if (scl_rise && !sda && byte_idx < 3'd5) begin
            state_nx = ST_TX_BYTE;
            idx_nx   = byte_idx + 3'd1;
          end else if (scl_rise) begin
            state_nx = ST_WAIT_STOP;
            rd_done  = 1'b1;
          end else begin
            state_nx = state;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  assign ready_clr = rd_done | ((start_det | stop_det) & sent);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      bit_cnt   <= 4'd0;
      shreg     <= 8'd0;
      byte_idx  <= 3'd0;
      rw_flag   <= 1'b0;
      sda_r     <= 1'b1;
      sent      <= 1'b0;
      Cmd_Error <= 1'b0;
    end else begin
      state     <= state_nx;
      bit_cnt   <= bit_cnt_nx;
      shreg     <= shreg_nx;
      byte_idx  <= idx_nx;
      rw_flag   <= rw_nx;
      sda_r     <= sda_nx;
      sent      <= sent_nx;
      Cmd_Error <= cmd_err_nx;
    end
  end

  // Countdown owns Meas_Busy; result words and CRCs are captured as it expires
  always_ff @(posedge clk) begin
    if (rst) begin
      Meas_Busy  <= 1'b0;
      Data_Ready <= 1'b0;
      meas_cnt   <= '0;
      t_word     <= 16'd0;
      rh_word    <= 16'd0;
      t_crc      <= 8'd0;
      rh_crc     <= 8'd0;
    end else if (meas_start) begin
      Meas_Busy  <= 1'b1;
      Data_Ready <= 1'b0;
      meas_cnt   <= CNT_W'(MEAS_CYCLES);
    end else if (Meas_Busy) begin
      meas_cnt <= meas_cnt - CNT_W'(1);
      if (meas_cnt == CNT_W'(1)) begin
        Meas_Busy  <= 1'b0;
        Data_Ready <= 1'b1;
        t_word     <= Temp_Value;
        rh_word    <= RH_Value;
        t_crc      <= t_crc_c;
        rh_crc     <= rh_crc_c;
      end
    end else if (ready_clr) begin
      Data_Ready <= 1'b0;
    end
  end

  // Reset releases the line immediately rather than waiting for the next edge
  assign Sda_Out = sda_r | rst;

endmodule

// File: tb/tb_i2c_sht40_target.sv
// Bench: a bit-banged I2C master drives the target; a bus monitor decodes every
// 9-bit frame and checks it against the expected-frame queue filled by the stimulus.
module tb_i2c_sht40_target;

  localparam int MEAS = 800;
  localparam int Q    = 5;
  localparam int H    = 10;

  typedef struct packed {
    logic [7:0] data;
    logic       ack;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst, scl_m, sda_m, sda_bus;
  logic        sda_o, busy, ready, cerr;
  logic [15:0] temp, rh;
  int          tests = 0;
  int          fails = 0;
  frame_t      exp_q[$];
  int          cyc = 0;
  int          busy_rise_cyc = 0;
  int          busy_fall_cyc = 0;
  int          ack_fall_cyc = 0;
  int          cerr_cnt = 0;
  bit          busy_fell = 1'b0;
  bit          sda_low_seen = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & sda_o;

  i2c_sht40_target #(.TARGET_ADDR(7'h44), .MEAS_CYCLES(MEAS)) dut (
    .clk(clk), .rst(rst), .Scl_In(scl_m), .Sda_In(sda_bus), .Sda_Out(sda_o),
    .Temp_Value(temp), .RH_Value(rh), .Meas_Busy(busy), .Data_Ready(ready),
    .Cmd_Error(cerr)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Status observer: busy edges, error pulses, any pull-down by the target
  initial begin : status_mon
    logic prev_busy;
    prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (busy === 1'b1 && !prev_busy) busy_rise_cyc = cyc;
      if (busy === 1'b0 && prev_busy) begin
        busy_fall_cyc = cyc;
        busy_fell     = 1'b1;
      end
      if (cerr === 1'b1) cerr_cnt++;
      if (sda_o === 1'b0) sda_low_seen = 1'b1;
      prev_busy = (busy === 1'b1);
    end
  end

  // Bus monitor: decodes frames and scores them against the expected queue
  initial begin : bus_mon
    logic       ps, pd, s, d;
    int         nb;
    logic [7:0] sh;
    frame_t     e;
    ps = 1'b1; pd = 1'b1; nb = 0; sh = 8'd0;
    forever begin
      @(negedge clk);
      s = scl_m;
      d = sda_bus;
      if (s && ps && pd && !d) nb = 0;
      else if (s && ps && !pd && d) nb = 0;
      else if (s && !ps) begin
        if (nb < 8) begin
          sh = {sh[6:0], d};
          nb++;
        end else begin
          nb = 0;
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL frame_unexpected: got byte %02h ack %0b expected none", sh, d);
          end else begin
            e = exp_q.pop_front();
            check("frame_byte", {24'd0, sh}, {24'd0, e.data});
            check("frame_ack", {31'd0, d}, {31'd0, e.ack});
          end
        end
      end
      ps = s;
      pd = d;
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    wclk(H); sda_m = 1'b0; wclk(H); scl_m = 1'b0;
  endtask

  task automatic i2c_rstart();
    wclk(Q); sda_m = 1'b1; wclk(Q); scl_m = 1'b1; wclk(H); sda_m = 1'b0; wclk(H); scl_m = 1'b0;
  endtask

  task automatic i2c_stop();
    wclk(Q); sda_m = 1'b0; wclk(Q); scl_m = 1'b1; wclk(H); sda_m = 1'b1; wclk(H);
  endtask

  task automatic bit_clk(input logic b);
    wclk(Q); sda_m = b; wclk(Q); scl_m = 1'b1; wclk(H); scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic ack_exp);
    exp_q.push_back('{data: b, ack: ack_exp});
    for (int i = 7; i >= 0; i--) bit_clk(b[i]);
    bit_clk(1'b1);
  endtask

  task automatic read_byte(input logic [7:0] exp_b, input logic mack);
    exp_q.push_back('{data: exp_b, ack: mack});
    for (int i = 0; i < 8; i++) bit_clk(1'b1);
    bit_clk(mack);
  endtask

  task automatic wait_meas_done();
    for (int i = 0; i < 2 * MEAS && !busy_fell; i++) @(negedge clk);
    check("meas_done_in_time", {31'd0, busy_fell}, 32'd1);
  endtask

  initial begin
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    temp = 16'hBEEF; rh = 16'h6666;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_sda_out", {31'd0, sda_o}, 32'd1);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_ready", {31'd0, ready}, 32'd0);
    check("reset_cmd_error", {31'd0, cerr}, 32'd0);

    // Start a measurement
    busy_fell = 1'b0;
    i2c_start();
    write_byte(8'h88, 1'b0);
    write_byte(8'hFD, 1'b0);
    ack_fall_cyc = cyc;
    i2c_stop();
    check("busy_after_cmd", {31'd0, busy}, 32'd1);
    check("busy_rise_latency", {31'd0, (busy_rise_cyc - ack_fall_cyc >= 1) && (busy_rise_cyc - ack_fall_cyc <= 8)}, 32'd1);

    // Read header while busy must be NACKed with SDA never pulled
    sda_low_seen = 1'b0;
    i2c_start();
    write_byte(8'h89, 1'b1);
    i2c_stop();
    check("busy_read_sda_released", {31'd0, sda_low_seen}, 32'd0);

    // Second FD while busy: NACK, no error pulse, count undisturbed
    cerr_cnt = 0;
    i2c_start();
    write_byte(8'h88, 1'b0);
    write_byte(8'hFD, 1'b1);
    i2c_stop();
    check("fd_busy_no_cmd_error", cerr_cnt, 32'd0);
    check("still_busy", {31'd0, busy}, 32'd1);

    wait_meas_done();
    check("busy_duration", busy_fall_cyc - busy_rise_cyc, MEAS);
    @(negedge clk);
    check("ready_after_meas", {31'd0, ready}, 32'd1);

    // Full read
    i2c_start();
    write_byte(8'h89, 1'b0);
    read_byte(8'hBE, 1'b0);
    read_byte(8'hEF, 1'b0);
    read_byte(8'h92, 1'b0);
    read_byte(8'h66, 1'b0);
    read_byte(8'h66, 1'b0);
    read_byte(8'h93, 1'b1);
    i2c_stop();
    check("ready_after_full_read", {31'd0, ready}, 32'd0);

    // Unsupported command, then wrong address
    cerr_cnt = 0;
    i2c_start();
    write_byte(8'h88, 1'b0);
    write_byte(8'h24, 1'b1);
    i2c_stop();
    check("cmd_error_pulses", cerr_cnt, 32'd1);
    i2c_start();
    write_byte(8'h90, 1'b1);
    i2c_stop();
    check("wrong_addr_cmd_error", cerr_cnt, 32'd1);
    check("wrong_addr_busy", {31'd0, busy}, 32'd0);
    check("wrong_addr_ready", {31'd0, ready}, 32'd0);

    // Partial read, then repeated-START read must be NACKed
    temp = 16'h1234;
    busy_fell = 1'b0;
    i2c_start();
    write_byte(8'h88, 1'b0);
    write_byte(8'hFD, 1'b0);
    i2c_stop();
    wait_meas_done();
    @(negedge clk);
    check("ready_second_meas", {31'd0, ready}, 32'd1);
    i2c_start();
    write_byte(8'h89, 1'b0);
    read_byte(8'h12, 1'b0);
    read_byte(8'h34, 1'b1);
    sda_low_seen = 1'b0;
    read_byte(8'hFF, 1'b1);
    check("no_drive_after_nack", {31'd0, sda_low_seen}, 32'd0);
    i2c_rstart();
    write_byte(8'h89, 1'b1);
    i2c_stop();
    check("ready_after_partial", {31'd0, ready}, 32'd0);

    wclk(20);
    check("all_frames_seen", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
